// File: rtl/port_packer.sv
// Packs a stream of DIN_WIDTH beats into a DOUT_WIDTH shadow word and commits it to
// dout one cycle after the tlast beat. Beats past N_WORDS are dropped and flagged as overrun.
module port_packer #(
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = 512
) (
    input  logic                                       aclk,
    input  logic                                       aresetn,
    input  logic [DIN_WIDTH-1:0]                       s_axis_tdata,
    input  logic                                       s_axis_tvalid,
    input  logic                                       s_axis_tlast,
    output logic                                       s_axis_tready,
    input  logic                                       clear_err,
    output logic [DOUT_WIDTH-1:0]                      dout,
    output logic                                       dout_update,
    output logic [$clog2(DOUT_WIDTH/DIN_WIDTH):0]      frame_len,
    output logic                                       overrun
);

    localparam int N_WORDS = DOUT_WIDTH / DIN_WIDTH;
    localparam int IDX_W   = $clog2(N_WORDS) + 1;
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(N_WORDS);

    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t                 state_r;
    logic [IDX_W-1:0]       idx_r;
    logic [DOUT_WIDTH-1:0]  shadow_r;
    logic [DOUT_WIDTH-1:0]  dout_r;
    logic                   dout_update_r;
    logic [IDX_W-1:0]       frame_len_r;
    logic                   overrun_r;
    logic                   ready_r;
    logic                   xfer_s;
    logic                   ovf_s;

    // Ready comes straight from a register, so it never depends on tvalid.
    assign xfer_s = s_axis_tvalid & ready_r;
    assign ovf_s  = xfer_s & (idx_r >= IDX_FULL);

    assign s_axis_tready = ready_r;
    assign dout          = dout_r;
    assign dout_update   = dout_update_r;
    assign frame_len     = frame_len_r;
    assign overrun       = overrun_r;

    // Fill/commit state machine with the shadow, index and committed output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r       <= ST_FILL;
            idx_r         <= {IDX_W{1'b0}};
            shadow_r      <= {DOUT_WIDTH{1'b0}};
            dout_r        <= {DOUT_WIDTH{1'b0}};
            dout_update_r <= 1'b0;
            frame_len_r   <= {IDX_W{1'b0}};
            ready_r       <= 1'b0;
        end else begin
            dout_update_r <= 1'b0;
            case (state_r)
                ST_FILL: begin
                    ready_r <= 1'b1;
                    if (xfer_s) begin
                        if (idx_r < IDX_FULL) begin
                            for (int i = 0; i < N_WORDS; i++) begin
                                if (idx_r == IDX_W'(i)) begin
                                    shadow_r[i*DIN_WIDTH +: DIN_WIDTH] <= s_axis_tdata;
                                end
                            end
                            idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                        if (s_axis_tlast) begin
                            state_r <= ST_COMMIT;
                            ready_r <= 1'b0;
                        end
                    end
                end
                ST_COMMIT: begin
                    // idx_r already counts the tlast beat and is saturated at N_WORDS.
                    dout_r        <= shadow_r;
                    dout_update_r <= 1'b1;
                    frame_len_r   <= idx_r;
                    idx_r         <= {IDX_W{1'b0}};
                    ready_r       <= 1'b1;
                    state_r       <= ST_FILL;
                end
                default: begin
                    state_r <= ST_FILL;
                    idx_r   <= {IDX_W{1'b0}};
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun flag; a new overrun event takes priority over clear_err.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overrun_r <= 1'b0;
        end else if (ovf_s) begin
            overrun_r <= 1'b1;
        end else if (clear_err) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

endmodule

// File: tb/tb_port_packer.sv
// Directed bench for port_packer with 32-bit beats packed into a 128-bit word.
module tb_port_packer;

    logic         aclk;
    logic         aresetn;
    logic [31:0]  s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic         clear_err;
    logic [127:0] dout;
    logic         dout_update;
    logic [2:0]   frame_len;
    logic         overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic         mon_en = 1'b0;
    logic [127:0] prev_dout;
    logic         prev_upd;

    port_packer #(.DIN_WIDTH(32), .DOUT_WIDTH(128)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .clear_err     (clear_err),
        .dout          (dout),
        .dout_update   (dout_update),
        .frame_len     (frame_len),
        .overrun       (overrun)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one beat after 'gap' idle cycles; returns at the negedge after it transfers.
    task automatic beat(input logic [31:0] d, input logic l, input int gap);
        int w;
        repeat (gap) @(negedge aclk);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        w = 0;
        while (!s_axis_tready && w < 20) begin
            @(negedge aclk);
            w++;
        end
        check("beat_ready", {127'd0, s_axis_tready}, 128'd1);
        @(posedge aclk);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // dout may only move together with dout_update, and dout_update never lasts two cycles.
    always @(negedge aclk) begin
        if (aresetn && mon_en) begin
            n_cmp++;
            assert (dout === prev_dout || dout_update === 1'b1) else begin
                n_err++;
                $error("FAIL dout_hold: observed %h expected %h", dout, prev_dout);
            end
            n_cmp++;
            assert (!(dout_update === 1'b1 && prev_upd === 1'b1)) else begin
                n_err++;
                $error("FAIL upd_pulse: observed %b%b expected not 11", prev_upd, dout_update);
            end
        end
        prev_dout = dout;
        prev_upd  = dout_update;
    end

    initial begin
        aresetn       = 1'b1;
        s_axis_tdata  = 32'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        clear_err     = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        check("rst_ready",  {127'd0, s_axis_tready}, 128'd0);
        check("rst_dout",   dout, 128'd0);
        check("rst_upd",    {127'd0, dout_update}, 128'd0);
        check("rst_len",    {125'd0, frame_len}, 128'd0);
        check("rst_ovr",    {127'd0, overrun}, 128'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        mon_en = 1'b1;
        check("rel_ready", {127'd0, s_axis_tready}, 128'd1);

        // Full back-to-back frame
        beat(32'h11111111, 1'b0, 0);
        beat(32'h22222222, 1'b0, 0);
        beat(32'h33333333, 1'b0, 0);
        beat(32'h44444444, 1'b1, 0);
        check("f1_commit_ready", {127'd0, s_axis_tready}, 128'd0);
        check("f1_dout_early",   dout, 128'd0);
        check("f1_upd_early",    {127'd0, dout_update}, 128'd0);
        @(negedge aclk);
        check("f1_dout",  dout, 128'h44444444_33333333_22222222_11111111);
        check("f1_upd",   {127'd0, dout_update}, 128'd1);
        check("f1_len",   {125'd0, frame_len}, 128'd4);
        check("f1_ready", {127'd0, s_axis_tready}, 128'd1);
        @(negedge aclk);
        check("f1_upd_end", {127'd0, dout_update}, 128'd0);

        // Partial frame updates only the low fields
        beat(32'hAAAAAAAA, 1'b0, 0);
        beat(32'hBBBBBBBB, 1'b1, 0);
        @(negedge aclk);
        check("f2_dout", dout, 128'h44444444_33333333_BBBBBBBB_AAAAAAAA);
        check("f2_len",  {125'd0, frame_len}, 128'd2);
        check("f2_upd",  {127'd0, dout_update}, 128'd1);

        // Overrunning six-beat frame, then clear
        beat(32'h1, 1'b0, 0);
        beat(32'h2, 1'b0, 0);
        beat(32'h3, 1'b0, 0);
        beat(32'h4, 1'b0, 0);
        check("f3_ovr_pre", {127'd0, overrun}, 128'd0);
        beat(32'h5, 1'b0, 0);
        check("f3_ovr_set", {127'd0, overrun}, 128'd1);
        beat(32'h6, 1'b1, 0);
        @(negedge aclk);
        check("f3_dout", dout, 128'h00000004_00000003_00000002_00000001);
        check("f3_len",  {125'd0, frame_len}, 128'd4);
        check("f3_ovr",  {127'd0, overrun}, 128'd1);
        clear_err = 1'b1;
        @(negedge aclk);
        clear_err = 1'b0;
        check("f3_ovr_clr", {127'd0, overrun}, 128'd0);

        // Gapped frames must commit the same as gap-free ones
        beat(32'h10, 1'b0, 3);
        beat(32'h20, 1'b0, 2);
        beat(32'h30, 1'b1, 1);
        @(negedge aclk);
        check("f4_dout", dout, 128'h00000004_00000030_00000020_00000010);
        check("f4_len",  {125'd0, frame_len}, 128'd3);
        beat(32'hA1, 1'b0, 4);
        beat(32'hA2, 1'b0, 0);
        beat(32'hA3, 1'b0, 2);
        beat(32'hA4, 1'b1, 1);
        @(negedge aclk);
        check("f5_dout", dout, 128'h000000A4_000000A3_000000A2_000000A1);
        check("f5_len",  {125'd0, frame_len}, 128'd4);
        check("f5_ovr",  {127'd0, overrun}, 128'd0);

        // clear_err held while the fifth beat overruns: set wins
        beat(32'h51, 1'b0, 0);
        beat(32'h52, 1'b0, 0);
        beat(32'h53, 1'b0, 0);
        beat(32'h54, 1'b0, 0);
        clear_err = 1'b1;
        beat(32'h55, 1'b1, 0);
        check("f6_ovr_setwins", {127'd0, overrun}, 128'd1);
        @(negedge aclk);
        check("f6_dout",    dout, 128'h00000054_00000053_00000052_00000051);
        check("f6_len",     {125'd0, frame_len}, 128'd4);
        check("f6_ovr_clr", {127'd0, overrun}, 128'd0);
        clear_err = 1'b0;

        // Reset mid-frame discards the partial frame
        beat(32'h77, 1'b0, 0);
        beat(32'h88, 1'b0, 0);
        #2 aresetn = 1'b0;
        #1;
        check("mr_ready", {127'd0, s_axis_tready}, 128'd0);
        check("mr_dout",  dout, 128'd0);
        check("mr_len",   {125'd0, frame_len}, 128'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("mr_rel_ready", {127'd0, s_axis_tready}, 128'd1);
        check("mr_no_commit", {127'd0, dout_update}, 128'd0);
        beat(32'h5, 1'b1, 0);
        @(negedge aclk);
        check("f7_dout", dout, 128'h00000000_00000000_00000000_00000005);
        check("f7_len",  {125'd0, frame_len}, 128'd1);
        check("f7_ovr",  {127'd0, overrun}, 128'd0);
        check("f7_upd",  {127'd0, dout_update}, 128'd1);
        repeat (3) @(negedge aclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/port_packer.md
PORT_PACKER -- requirements
Module: port_packer

Interface
REQ-001 Parameter DIN_WIDTH, default 32, width of one input stream beat.
REQ-002 Parameter DOUT_WIDTH, default 512, width of the packed output word; SHALL be an integer multiple of DIN_WIDTH, N_WORDS = DOUT_WIDTH/DIN_WIDTH, N_WORDS >= 2.
REQ-003 aclk  input  1  single clock; all logic rising-edge.
REQ-004 aresetn  input  1  asynchronous active-low reset.
REQ-005 s_axis_tdata  input  DIN_WIDTH  input beat data.
REQ-006 s_axis_tvalid  input  1  beat valid.
REQ-007 s_axis_tlast  input  1  last beat of frame.
REQ-008 s_axis_tready  output  1  block accepts beat.
REQ-009 clear_err  input  1  level; clears overrun flag.
REQ-010 dout  output  DOUT_WIDTH  packed word, registered; consumers slice fields from it.
REQ-011 dout_update  output  1  one-cycle pulse when dout changes.
REQ-012 frame_len  output  clog2(N_WORDS)+1  beats written in the last committed frame, saturating at N_WORDS.
REQ-013 overrun  output  1  sticky; a frame exceeded N_WORDS beats.

Function
REQ-014 A beat transfers when s_axis_tvalid and s_axis_tready are both 1 on a rising aclk edge; no other beat has effect.
REQ-015 Block SHALL hold a DOUT_WIDTH shadow register and a word index idx; transfer k of a frame (k from 0) writes shadow[k*DIN_WIDTH +: DIN_WIDTH] when k < N_WORDS.
REQ-016 Shadow words not written in a frame SHALL retain prior values (partial frames update low fields only).
REQ-017 State machine states: FILL, COMMIT.
REQ-018 FILL: s_axis_tready = 1; each transfer increments idx, saturating at N_WORDS; a transfer with tlast = 1 moves to COMMIT.
REQ-019 COMMIT (exactly one cycle): s_axis_tready = 0; dout <= shadow; dout_update = 1; frame_len <= beats of frame (saturated); idx <= 0; next state FILL.
REQ-020 Latency: dout and dout_update valid on the edge after the cycle following the tlast transfer (tlast transfer at edge n, dout changes at edge n+1, dout_update high cycle n+1 to n+2).
REQ-021 Tlast beat data SHALL be included in the commit when its index < N_WORDS.
REQ-022 Beats with index >= N_WORDS SHALL be accepted and discarded, set overrun on that edge, and not stall the stream; frame still commits on tlast with the first N_WORDS beats.
REQ-023 Single-beat frame (tlast on first beat) SHALL commit with frame_len = 1.
REQ-024 overrun cleared by clear_err = 1; if clear_err and a new overrun event coincide, overrun SHALL be 1 (set wins).
REQ-025 dout SHALL change only in COMMIT; dout_update SHALL never be high for two consecutive cycles.
REQ-026 s_axis_tready SHALL be registered-state derived only, not combinationally dependent on s_axis_tvalid.

Reset
REQ-027 aresetn low SHALL asynchronously force: state FILL, idx 0, shadow 0, dout 0, dout_update 0, frame_len 0, overrun 0; s_axis_tready SHALL be 0 while aresetn is low.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; no commit follows; after release, first transfer is index 0.
REQ-029 After aresetn deasserts, s_axis_tready SHALL be 1 from the first rising edge.

Verification (DIN_WIDTH=32, DOUT_WIDTH=128, N_WORDS=4)
REQ-030 Beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 (tlast on 4th) back-to-back -> one cycle later dout = 0x44444444_33333333_22222222_11111111, dout_update single pulse, frame_len = 4, tready low exactly one cycle.
REQ-031 After REQ-030, frame of 2 beats 0xAAAAAAAA, 0xBBBBBBBB (tlast) -> dout = 0x44444444_33333333_BBBBBBBB_AAAAAAAA, frame_len = 2.
REQ-032 Six-beat frame 1..6, tlast on 6 -> dout = 0x00000004_00000003_00000002_00000001, frame_len = 4, overrun = 1; clear_err pulse -> overrun = 0.
REQ-033 Beats with tvalid toggled randomly and gaps between frames -> commits identical to gap-free case; no dout change except with dout_update.
REQ-034 Reset asserted after 2 beats of a frame, released, then a 1-beat frame 0x5 with tlast -> dout = 0x00000000_00000000_00000000_00000005, frame_len = 1, overrun = 0.
REQ-035 clear_err held high while a 5th beat of an overrunning frame transfers -> overrun = 1 after that edge.
